control_unit: RTL and testbench

Multicycle control FSM for the 16-bit CPU datapath. Decodes `Opcode` (IR[15:8]) and `Flags`, and sequences fetch, execute, load/store and branch. Drives every select and enable input of the datapath plus the external memory strobes. Sits beside the datapath in the CPU top level, with one clock and one shared SysBus.

---
 rtl/opcodes.sv | 77 +++++++
 rtl/cond_check.sv | 25 ++
 rtl/control_unit.sv | 187 ++++++++++++++++++
 tb/tb_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/opcodes.sv
// Shared encodings for the 16-bit CPU: ALU functions, datapath selects,
// control states, instruction classes, condition codes and flag positions.
package opcodes;

  localparam int unsigned OpcodeW = 8;
  localparam int unsigned FlagsW  = 4;
  localparam int unsigned CondW   = 3;
  localparam int unsigned AluFnW  = 3;
  localparam int unsigned ClassW  = 5;

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  typedef enum logic [AluFnW-1:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluXor  = 3'd4,
    AluAdc  = 3'd5,
    AluSbc  = 3'd6,
    AluPass = 3'd7
  } alu_functions_t;

  typedef enum logic [1:0] {Pc1, PcAluOut, PcLr} pc_sel_t;
  typedef enum logic {Op1Rd1, Op1Pc} op1_sel_t;
  typedef enum logic {Op2Rd2, Op2Imm} op2_sel_t;
  typedef enum logic {ImmShort, ImmLong} imm_sel_t;
  typedef enum logic {WdAlu, WdSys} wd_sel_t;
  typedef enum logic {Rs1Ir, Rs1Rd} rs1_sel_t;
  typedef enum logic {LrPc, LrSys} lr_sel_t;

  typedef enum logic [3:0] {
    FETCH_A, FETCH_D, EXEC, LD_A, LD_D, ST_A, ST_P, ST_D, BL_B, HALT
  } state_t;

  // Opcode[7:3] class codes; ALU classes only look at the top two bits
  localparam logic [1:0]        ClsAluReg = 2'b00;
  localparam logic [1:0]        ClsAluImm = 2'b01;
  localparam logic [ClassW-1:0] ClsLdw    = 5'b10000;
  localparam logic [ClassW-1:0] ClsStw    = 5'b10001;
  localparam logic [ClassW-1:0] ClsBcc    = 5'b11000;
  localparam logic [ClassW-1:0] ClsBl     = 5'b11100;
  localparam logic [ClassW-1:0] ClsRet    = 5'b11101;
  localparam logic [ClassW-1:0] ClsHalt   = 5'b11111;

  localparam logic [CondW-1:0] CondAl = 3'b000;
  localparam logic [CondW-1:0] CondEq = 3'b001;
  localparam logic [CondW-1:0] CondNe = 3'b010;
  localparam logic [CondW-1:0] CondCs = 3'b011;
  localparam logic [CondW-1:0] CondCc = 3'b100;
  localparam logic [CondW-1:0] CondMi = 3'b101;
  localparam logic [CondW-1:0] CondPl = 3'b110;
  localparam logic [CondW-1:0] CondVs = 3'b111;

  typedef enum logic [3:0] {
    InstAluReg, InstAluImm, InstLdw, InstStw, InstBcc,
    InstBl, InstRet, InstHalt, InstNop
  } inst_t;

  function automatic inst_t decode_class(input logic [ClassW-1:0] cls);
    inst_t inst;
    inst = InstNop;
    if (cls[ClassW-1 -: 2] == ClsAluReg)      inst = InstAluReg;
    else if (cls[ClassW-1 -: 2] == ClsAluImm) inst = InstAluImm;
    else if (cls == ClsLdw)                   inst = InstLdw;
    else if (cls == ClsStw)                   inst = InstStw;
    else if (cls == ClsBcc)                   inst = InstBcc;
    else if (cls == ClsBl)                    inst = InstBl;
    else if (cls == ClsRet)                   inst = InstRet;
    else if (cls == ClsHalt)                  inst = InstHalt;
    return inst;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Branch condition evaluation against the stored status flags.
module cond_check
  import opcodes::*;
(
  input  logic [CondW-1:0]  cond,
  input  logic [FlagsW-1:0] status,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CondAl:  taken = 1'b1;
      CondEq:  taken = status[FlagZ];
      CondNe:  taken = !status[FlagZ];
      CondCs:  taken = status[FlagC];
      CondCc:  taken = !status[FlagC];
      CondMi:  taken = status[FlagN];
      CondPl:  taken = !status[FlagN];
      CondVs:  taken = status[FlagV];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit CPU: sequences fetch, execute,
// load/store and branch, and drives all datapath selects and bus strobes.
module control_unit
  import opcodes::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OpcodeW-1:0]  Opcode,
  input  logic [FlagsW-1:0]   Flags,
  input  logic                Ready,
  output alu_functions_t      AluOp,
  output pc_sel_t             PcSel,
  output op1_sel_t            Op1Sel,
  output op2_sel_t            Op2Sel,
  output imm_sel_t            ImmSel,
  output wd_sel_t             WdSel,
  output rs1_sel_t            Rs1Sel,
  output lr_sel_t             LrSel,
  output logic                AluEn,
  output logic                LrEn,
  output logic                PcEn,
  output logic                MemEn,
  output logic                AluWe,
  output logic                LrWe,
  output logic                PcWe,
  output logic                IrWe,
  output logic                RegWe,
  output logic                CFlag,
  output logic                ALE,
  output logic                nOE,
  output logic                nWE
);

  state_t              state;
  state_t              state_next;
  logic [FlagsW-1:0]   status;
  logic                status_we;
  logic                taken;
  inst_t               inst;

  assign inst  = decode_class(Opcode[OpcodeW-1 -: ClassW]);
  assign CFlag = status[FlagC];

  cond_check u_cond_check (
    .cond   (Opcode[CondW-1:0]),
    .status (status),
    .taken  (taken)
  );

  // State and status register; reset wins over every state including HALT
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= FETCH_A;
      status <= '0;
    end else begin
      state <= state_next;
      if (status_we) status <= Flags;
    end
  end

  // Next state and Moore outputs; everything stays idle while Reset is high
  always_comb begin
    state_next = state;
    status_we  = 1'b0;
    AluOp      = AluPass;
    PcSel      = Pc1;
    Op1Sel     = Op1Rd1;
    Op2Sel     = Op2Rd2;
    ImmSel     = ImmShort;
    WdSel      = WdAlu;
    Rs1Sel     = Rs1Ir;
    LrSel      = LrPc;
    AluEn      = 1'b0;
    LrEn       = 1'b0;
    PcEn       = 1'b0;
    MemEn      = 1'b0;
    AluWe      = 1'b0;
    LrWe       = 1'b0;
    PcWe       = 1'b0;
    IrWe       = 1'b0;
    RegWe      = 1'b0;
    ALE        = 1'b0;
    nOE        = 1'b1;
    nWE        = 1'b1;

    if (!Reset) begin
      case (state)
        FETCH_A: begin
          PcEn       = 1'b1;
          ALE        = 1'b1;
          state_next = FETCH_D;
        end
        FETCH_D: begin
          MemEn = 1'b1;
          nOE   = 1'b0;
          if (Ready) begin
            IrWe       = 1'b1;
            PcSel      = Pc1;
            PcWe       = 1'b1;
            state_next = EXEC;
          end
        end
        EXEC: begin
          state_next = FETCH_A;
          case (inst)
            InstAluReg, InstAluImm: begin
              AluOp     = alu_functions_t'(Opcode[CondW +: AluFnW]);
              Op1Sel    = Op1Rd1;
              Op2Sel    = (inst == InstAluImm) ? Op2Imm : Op2Rd2;
              ImmSel    = ImmShort;
              WdSel     = WdAlu;
              RegWe     = 1'b1;
              status_we = 1'b1;
            end
            InstLdw, InstStw: begin
              Rs1Sel     = Rs1Ir;
              Op1Sel     = Op1Rd1;
              Op2Sel     = Op2Imm;
              ImmSel     = ImmShort;
              AluOp      = AluAdd;
              AluWe      = 1'b1;
              state_next = (inst == InstLdw) ? LD_A : ST_A;
            end
            InstBcc: begin
              Op1Sel = Op1Pc;
              Op2Sel = Op2Imm;
              ImmSel = ImmLong;
              AluOp  = AluAdd;
              PcSel  = PcAluOut;
              PcWe   = taken;
            end
            InstBl: begin
              LrSel      = LrPc;
              LrWe       = 1'b1;
              state_next = BL_B;
            end
            InstRet: begin
              PcSel = PcLr;
              PcWe  = 1'b1;
            end
            InstHalt: state_next = HALT;
            default:  state_next = FETCH_A;
          endcase
        end
        LD_A, ST_A: begin
          AluEn      = 1'b1;
          ALE        = 1'b1;
          state_next = (state == LD_A) ? LD_D : ST_P;
        end
        LD_D: begin
          MemEn = 1'b1;
          nOE   = 1'b0;
          WdSel = WdSys;
          if (Ready) begin
            RegWe      = 1'b1;
            state_next = FETCH_A;
          end
        end
        // Address is latched; route Rd through the ALU to become store data
        ST_P: begin
          Rs1Sel     = Rs1Rd;
          Op1Sel     = Op1Rd1;
          AluOp      = AluPass;
          AluWe      = 1'b1;
          state_next = ST_D;
        end
        ST_D: begin
          AluEn = 1'b1;
          nWE   = 1'b0;
          if (Ready) state_next = FETCH_A;
        end
        BL_B: begin
          Op1Sel     = Op1Pc;
          Op2Sel     = Op2Imm;
          ImmSel     = ImmLong;
          AluOp      = AluAdd;
          PcSel      = PcAluOut;
          PcWe       = 1'b1;
          state_next = FETCH_A;
        end
        HALT:    state_next = HALT;
        default: state_next = FETCH_A;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-cycle input records with
// hand-computed strobe, PcSel, AluOp and CFlag expectations.
module tb_control_unit;
  import opcodes::*;

  logic           Clock;
  logic           Reset;
  logic [7:0]     Opcode;
  logic [3:0]     Flags;
  logic           Ready;
  alu_functions_t AluOp;
  pc_sel_t        PcSel;
  op1_sel_t       Op1Sel;
  op2_sel_t       Op2Sel;
  imm_sel_t       ImmSel;
  wd_sel_t        WdSel;
  rs1_sel_t       Rs1Sel;
  lr_sel_t        LrSel;
  logic AluEn, LrEn, PcEn, MemEn, AluWe, LrWe, PcWe, IrWe, RegWe;
  logic CFlag, ALE, nOE, nWE;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Flags(Flags), .Ready(Ready),
    .AluOp(AluOp), .PcSel(PcSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel),
    .ImmSel(ImmSel), .WdSel(WdSel), .Rs1Sel(Rs1Sel), .LrSel(LrSel),
    .AluEn(AluEn), .LrEn(LrEn), .PcEn(PcEn), .MemEn(MemEn),
    .AluWe(AluWe), .LrWe(LrWe), .PcWe(PcWe), .IrWe(IrWe), .RegWe(RegWe),
    .CFlag(CFlag), .ALE(ALE), .nOE(nOE), .nWE(nWE)
  );

  // Strobe word: {AluEn,LrEn,PcEn,MemEn,AluWe,LrWe,PcWe,IrWe,RegWe,ALE,nOE,nWE}
  localparam logic [11:0] S_IDLE = 12'h003;
  localparam logic [11:0] S_FA   = 12'h207;
  localparam logic [11:0] S_MRW  = 12'h101;
  localparam logic [11:0] S_FDR  = 12'h131;
  localparam logic [11:0] S_ALU  = 12'h00B;
  localparam logic [11:0] S_AGU  = 12'h083;
  localparam logic [11:0] S_PCW  = 12'h023;
  localparam logic [11:0] S_LRW  = 12'h043;
  localparam logic [11:0] S_ADR  = 12'h807;
  localparam logic [11:0] S_LDR  = 12'h109;
  localparam logic [11:0] S_STD  = 12'h802;
  localparam logic [3:0]  F0     = 4'h0;

  typedef struct {
    logic           rst;
    logic [7:0]     opc;
    logic [3:0]     flg;
    logic           rdy;
    logic [11:0]    strb;
    logic           cf;
    logic           chk_pc;
    pc_sel_t        pc;
    logic           chk_alu;
    alu_functions_t alu;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] strobes();
    return {AluEn, LrEn, PcEn, MemEn, AluWe, LrWe, PcWe, IrWe, RegWe, ALE, nOE, nWE};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [7:0] opc, input logic [3:0] flg,
                              input logic rdy, input logic [11:0] strb, input logic cf,
                              input logic chk_pc = 1'b0, input pc_sel_t pc = Pc1,
                              input logic chk_alu = 1'b0, input alu_functions_t alu = AluPass);
    vec_t v;
    v.rst = rst; v.opc = opc; v.flg = flg; v.rdy = rdy; v.strb = strb; v.cf = cf;
    v.chk_pc = chk_pc; v.pc = pc; v.chk_alu = chk_alu; v.alu = alu;
    return v;
  endfunction

  // Fetch with Ready low in FETCH_A (must be ignored) and zero wait states
  task automatic fetch(input logic [7:0] opc, input logic cf);
    vq.push_back(mk(1'b0, opc, F0, 1'b0, S_FA, cf));
    vq.push_back(mk(1'b0, opc, F0, 1'b1, S_FDR, cf, 1'b1, Pc1));
  endtask

  task automatic apply(input string tag, input int idx, input vec_t v);
    Reset = v.rst; Opcode = v.opc; Flags = v.flg; Ready = v.rdy;
    @(negedge Clock);
    checks++;
    if (strobes() !== v.strb) begin
      failures++;
      $display("FAIL %s[%0d] strobes actual=%03h required=%03h", tag, idx, strobes(), v.strb);
    end
    if (v.chk_pc) begin
      checks++;
      if (PcSel !== v.pc) begin
        failures++;
        $display("FAIL %s[%0d] PcSel actual=%0d required=%0d", tag, idx, PcSel, v.pc);
      end
    end
    if (v.chk_alu) begin
      checks++;
      if (AluOp !== v.alu) begin
        failures++;
        $display("FAIL %s[%0d] AluOp actual=%0d required=%0d", tag, idx, AluOp, v.alu);
      end
    end
    if (!v.rst) begin
      checks++;
      if (CFlag !== v.cf) begin
        failures++;
        $display("FAIL %s[%0d] CFlag actual=%0b required=%0b", tag, idx, CFlag, v.cf);
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < vq.size(); i++) apply(tag, i, vq[i]);
    vq.delete();
  endtask

  initial begin
    Reset = 1'b1; Opcode = 8'h00; Flags = F0; Ready = 1'b0;

    // Main table: reset, then one instruction of each class
    vq.push_back(mk(1'b1, 8'h00, F0, 1'b0, S_IDLE, 1'b0));
    vq.push_back(mk(1'b1, 8'h00, F0, 1'b1, S_IDLE, 1'b0));
    vq.push_back(mk(1'b0, 8'h01, F0, 1'b0, S_FA, 1'b0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1'b0, 8'h01, F0, 1'b0, S_MRW, 1'b0));
    vq.push_back(mk(1'b0, 8'h01, F0, 1'b1, S_FDR, 1'b0, 1'b1, Pc1));
    vq.push_back(mk(1'b0, 8'h01, F0, 1'b1, S_ALU, 1'b0, 1'b0, Pc1, 1'b1, AluAdd));
    fetch(8'h48, 1'b0);
    vq.push_back(mk(1'b0, 8'h48, 4'b1000, 1'b1, S_ALU, 1'b0, 1'b0, Pc1, 1'b1, AluSub));
    fetch(8'hC1, 1'b0);
    vq.push_back(mk(1'b0, 8'hC1, F0, 1'b1, S_PCW, 1'b0, 1'b1, PcAluOut, 1'b1, AluAdd));
    fetch(8'hC2, 1'b0);
    vq.push_back(mk(1'b0, 8'hC2, F0, 1'b1, S_IDLE, 1'b0));
    fetch(8'hC3, 1'b0);
    vq.push_back(mk(1'b0, 8'hC3, 4'b0100, 1'b1, S_IDLE, 1'b0));
    fetch(8'hC4, 1'b0);
    vq.push_back(mk(1'b0, 8'hC4, F0, 1'b1, S_PCW, 1'b0, 1'b1, PcAluOut));
    fetch(8'h80, 1'b0);
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_AGU, 1'b0, 1'b0, Pc1, 1'b1, AluAdd));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_ADR, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b0, S_MRW, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_LDR, 1'b0));
    fetch(8'h88, 1'b0);
    vq.push_back(mk(1'b0, 8'h88, F0, 1'b1, S_AGU, 1'b0, 1'b0, Pc1, 1'b1, AluAdd));
    vq.push_back(mk(1'b0, 8'h88, F0, 1'b0, S_ADR, 1'b0));
    vq.push_back(mk(1'b0, 8'h88, F0, 1'b0, S_AGU, 1'b0, 1'b0, Pc1, 1'b1, AluPass));
    vq.push_back(mk(1'b0, 8'h88, F0, 1'b0, S_STD, 1'b0));
    vq.push_back(mk(1'b0, 8'h88, F0, 1'b1, S_STD, 1'b0));
    fetch(8'hE0, 1'b0);
    vq.push_back(mk(1'b0, 8'hE0, F0, 1'b1, S_LRW, 1'b0));
    vq.push_back(mk(1'b0, 8'hE0, F0, 1'b1, S_PCW, 1'b0, 1'b1, PcAluOut, 1'b1, AluAdd));
    fetch(8'hE8, 1'b0);
    vq.push_back(mk(1'b0, 8'hE8, F0, 1'b1, S_PCW, 1'b0, 1'b1, PcLr));
    fetch(8'h40, 1'b0);
    vq.push_back(mk(1'b0, 8'h40, 4'b0100, 1'b1, S_ALU, 1'b0, 1'b0, Pc1, 1'b1, AluAdd));
    fetch(8'hA0, 1'b1);
    vq.push_back(mk(1'b0, 8'hA0, 4'b1111, 1'b1, S_IDLE, 1'b1));
    fetch(8'hC3, 1'b1);
    vq.push_back(mk(1'b0, 8'hC3, F0, 1'b1, S_PCW, 1'b1, 1'b1, PcAluOut));
    run("main");

    // HALT holds for 20 cycles regardless of Ready; only Reset leaves it
    fetch(8'hF8, 1'b1);
    vq.push_back(mk(1'b0, 8'hF8, F0, 1'b1, S_IDLE, 1'b1));
    for (int i = 0; i < 20; i++)
      vq.push_back(mk(1'b0, 8'hF8, 4'b1111, 1'(i % 2), S_IDLE, 1'b1));
    vq.push_back(mk(1'b1, 8'hF8, F0, 1'b1, S_IDLE, 1'b1));
    vq.push_back(mk(1'b0, 8'hA0, F0, 1'b0, S_FA, 1'b0));
    vq.push_back(mk(1'b0, 8'hA0, F0, 1'b1, S_FDR, 1'b0, 1'b1, Pc1));
    vq.push_back(mk(1'b0, 8'hA0, F0, 1'b1, S_IDLE, 1'b0));
    run("halt");

    // Reset held for two cycles while LD_D waits on memory
    fetch(8'h80, 1'b0);
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_AGU, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_ADR, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b0, S_MRW, 1'b0));
    vq.push_back(mk(1'b1, 8'h80, F0, 1'b0, S_IDLE, 1'b0));
    vq.push_back(mk(1'b1, 8'h80, F0, 1'b1, S_IDLE, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_FA, 1'b0));
    vq.push_back(mk(1'b0, 8'h80, F0, 1'b1, S_FDR, 1'b0, 1'b1, Pc1));
    run("ldrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
